// File: rtl/stall_ctrl_if.sv
// Bundle between the pipeline stages and the central stall/flush controller.
// The stage side is the master. The controller is the slave and also exposes its FSM state for debug.
interface stall_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);
  // EXCEPT_REQ is a level request: the requester holds it, with EXCEPT_PC stable,
  // until it observes FLUSH = 1, then drops it. FLUSH acts as the acknowledge.
  // The stall requests have no handshake: each is sampled every cycle.
  logic              STALLREQ_IF;
  logic              STALLREQ_ID;
  logic              STALLREQ_EX;
  logic              STALLREQ_MEM;
  logic              EXCEPT_REQ;
  logic [ADDR_W-1:0] EXCEPT_PC;
  logic [5:0]        STALL;
  logic              FLUSH;
  logic [ADDR_W-1:0] NEW_PC;
  logic [CNT_W-1:0]  STALL_CYCLES;
  logic              WATCHDOG_TO;
  logic [1:0]        DBG_STATE;

  modport master (
    output STALLREQ_IF, STALLREQ_ID, STALLREQ_EX, STALLREQ_MEM,
    output EXCEPT_REQ, EXCEPT_PC,
    input  STALL, FLUSH, NEW_PC, STALL_CYCLES, WATCHDOG_TO, DBG_STATE
  );

  modport slave (
    input  STALLREQ_IF, STALLREQ_ID, STALLREQ_EX, STALLREQ_MEM,
    input  EXCEPT_REQ, EXCEPT_PC,
    output STALL, FLUSH, NEW_PC, STALL_CYCLES, WATCHDOG_TO, DBG_STATE
  );
endinterface

// File: rtl/stall_ctrl.sv
// Pipeline stall arbitration, exception flush sequencing (IDLE -> PEND -> FLUSH),
// stall-cycle performance counter and sticky stall watchdog.
module stall_ctrl #(
  parameter int WDOG_LIMIT = 1024,
  parameter int CNT_W      = 16,
  parameter int ADDR_W     = 32
) (
  input  logic         CLK,
  input  logic         RST,
  stall_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND    = 2'd1,
    FLUSH_S = 2'd2
  } state_t;

  localparam logic [5:0]       STALL_MEM = 6'b011111;
  localparam logic [5:0]       STALL_EX  = 6'b001111;
  localparam logic [5:0]       STALL_ID  = 6'b000111;
  localparam logic [5:0]       STALL_IF  = 6'b000011;
  localparam logic [5:0]       STALL_ALL = 6'b111111;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] WDOG_MAX  = CNT_W'(WDOG_LIMIT);

  state_t            state;
  logic [5:0]        stall_c;
  logic              flush_q;
  logic [ADDR_W-1:0] new_pc_q;
  logic [ADDR_W-1:0] pc_q;
  logic [CNT_W-1:0]  stall_cycles_q;
  logic [CNT_W-1:0]  wdog_cnt;
  logic              wdog_to_q;

  // Deepest requester wins; in PEND the whole pipe freezes while the flush is prepared.
  always_comb begin
    stall_c = '0;
    case (state)
      IDLE: begin
        if (bus.STALLREQ_MEM)     stall_c = STALL_MEM;
        else if (bus.STALLREQ_EX) stall_c = STALL_EX;
        else if (bus.STALLREQ_ID) stall_c = STALL_ID;
        else if (bus.STALLREQ_IF) stall_c = STALL_IF;
        else                      stall_c = '0;
      end
      PEND:    stall_c = STALL_ALL;
      default: stall_c = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= IDLE;
      flush_q        <= 1'b0;
      new_pc_q       <= '0;
      pc_q           <= '0;
      stall_cycles_q <= '0;
      wdog_cnt       <= '0;
      wdog_to_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A pending MEM bus access must complete before the exception is taken.
          if (bus.EXCEPT_REQ && !bus.STALLREQ_MEM) begin
            state <= PEND;
            pc_q  <= bus.EXCEPT_PC;
          end
          flush_q  <= 1'b0;
          new_pc_q <= '0;
        end
        PEND: begin
          state    <= FLUSH_S;
          flush_q  <= 1'b1;
          new_pc_q <= pc_q;
        end
        FLUSH_S: begin
          state    <= IDLE;
          flush_q  <= 1'b0;
          new_pc_q <= '0;
        end
        default: begin
          state    <= IDLE;
          flush_q  <= 1'b0;
          new_pc_q <= '0;
        end
      endcase

      if (stall_c[0] && (stall_cycles_q != CNT_MAX))
        stall_cycles_q <= stall_cycles_q + 1'b1;

      // Only arbitration stalls feed the watchdog; the PEND freeze is bounded by design.
      if ((state == IDLE) && (stall_c != 6'b000000)) begin
        if (wdog_cnt != WDOG_MAX) begin
          wdog_cnt <= wdog_cnt + 1'b1;
          if (wdog_cnt == (WDOG_MAX - 1'b1))
            wdog_to_q <= 1'b1;
        end
      end else begin
        wdog_cnt <= '0;
      end
    end
  end

  assign bus.STALL        = stall_c;
  assign bus.FLUSH        = flush_q;
  assign bus.NEW_PC       = new_pc_q;
  assign bus.STALL_CYCLES = stall_cycles_q;
  assign bus.WATCHDOG_TO  = wdog_to_q;
  assign bus.DBG_STATE    = state;

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed bench for stall_ctrl: arbitration, flush latency, MEM-vs-exception ordering,
// watchdog, counter saturation and reset abort, with hand-computed expectations.
module tb_stall_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  stall_ctrl_if #(.ADDR_W(32), .CNT_W(4)) bus ();

  stall_ctrl #(
    .WDOG_LIMIT(4),
    .CNT_W     (4),
    .ADDR_W    (32)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic r_if, input logic r_id, input logic r_ex, input logic r_mem);
    bus.STALLREQ_IF  = r_if;
    bus.STALLREQ_ID  = r_id;
    bus.STALLREQ_EX  = r_ex;
    bus.STALLREQ_MEM = r_mem;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_stall"},  32'(bus.STALL),       32'h0);
    check_eq({tag, "_flush"},  32'(bus.FLUSH),       32'h0);
    check_eq({tag, "_new_pc"}, bus.NEW_PC,           32'h0);
    check_eq({tag, "_state"},  32'(bus.DBG_STATE),   32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    drive_req(1'b0, 1'b0, 1'b0, 1'b0);
    bus.EXCEPT_REQ = 1'b0;
    bus.EXCEPT_PC  = 32'h0;

    // Reset then idle
    step();
    step();
    rst = 1'b0;
    check_idle_outputs("reset");
    check_eq("reset_cycles", 32'(bus.STALL_CYCLES), 32'd0);
    check_eq("reset_wdog",   32'(bus.WATCHDOG_TO),  32'd0);

    // Priority: ID+EX -> EX wins, then ID alone, then nothing
    drive_req(1'b0, 1'b1, 1'b1, 1'b0);
    #1 check_eq("prio_ex_id", 32'(bus.STALL), 32'h0F);
    step();
    drive_req(1'b0, 1'b1, 1'b0, 1'b0);
    #1 check_eq("prio_id", 32'(bus.STALL), 32'h07);
    step();
    drive_req(1'b1, 1'b0, 1'b0, 1'b1);
    #1 check_eq("prio_mem_if", 32'(bus.STALL), 32'h1F);
    drive_req(1'b0, 1'b0, 1'b0, 1'b0);
    #1 check_eq("prio_none", 32'(bus.STALL), 32'h00);
    step();
    check_eq("prio_cycles", 32'(bus.STALL_CYCLES), 32'd2);

    // Exception with no stalls: PEND at n+1, FLUSH at n+2
    bus.EXCEPT_REQ = 1'b1;
    bus.EXCEPT_PC  = 32'hBFC00380;
    step();
    check_eq("exc_pend_stall", 32'(bus.STALL),     32'h3F);
    check_eq("exc_pend_flush", 32'(bus.FLUSH),     32'h0);
    check_eq("exc_pend_state", 32'(bus.DBG_STATE), 32'd1);
    drive_req(1'b1, 1'b1, 1'b1, 1'b1);
    #1 check_eq("exc_pend_ignore", 32'(bus.STALL), 32'h3F);
    drive_req(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_eq("exc_flush",        32'(bus.FLUSH), 32'h1);
    check_eq("exc_flush_pc",     bus.NEW_PC,     32'hBFC00380);
    check_eq("exc_flush_stall",  32'(bus.STALL), 32'h0);
    bus.EXCEPT_REQ = 1'b0;
    step();
    check_idle_outputs("exc_after");
    check_eq("exc_cycles", 32'(bus.STALL_CYCLES), 32'd3);

    // Exception held off by a MEM stall for 3 cycles
    bus.EXCEPT_REQ = 1'b1;
    bus.EXCEPT_PC  = 32'h80000180;
    drive_req(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1 check_eq($sformatf("memx_stall%0d", i), 32'(bus.STALL), 32'h1F);
      check_eq($sformatf("memx_state%0d", i), 32'(bus.DBG_STATE), 32'd0);
      step();
    end
    drive_req(1'b0, 1'b0, 1'b0, 1'b0);
    #1 check_eq("memx_release", 32'(bus.STALL), 32'h00);
    step();
    check_eq("memx_pend_stall", 32'(bus.STALL), 32'h3F);
    check_eq("memx_pend_flush", 32'(bus.FLUSH), 32'h0);
    step();
    check_eq("memx_flush",    32'(bus.FLUSH), 32'h1);
    check_eq("memx_flush_pc", bus.NEW_PC,     32'h80000180);
    bus.EXCEPT_REQ = 1'b0;
    step();
    check_idle_outputs("memx_after");
    check_eq("memx_cycles", 32'(bus.STALL_CYCLES), 32'd7);
    check_eq("memx_wdog",   32'(bus.WATCHDOG_TO),  32'd0);

    // Watchdog: two 3-cycle stalls with a gap never trip it
    drive_req(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
    drive_req(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive_req(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
    drive_req(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_eq("wdog_gap", 32'(bus.WATCHDOG_TO), 32'd0);
    check_eq("wdog_gap_cycles", 32'(bus.STALL_CYCLES), 32'd13);

    // Watchdog: held IF stall trips after the 4th stalled cycle and sticks
    drive_req(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
    check_eq("wdog_3", 32'(bus.WATCHDOG_TO), 32'd0);
    step();
    check_eq("wdog_4", 32'(bus.WATCHDOG_TO), 32'd1);
    drive_req(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_eq("wdog_sticky", 32'(bus.WATCHDOG_TO), 32'd1);

    // Counter saturation at 15 with CNT_W = 4
    check_eq("sat_cycles", 32'(bus.STALL_CYCLES), 32'd15);
    drive_req(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) step();
    drive_req(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("sat_hold", 32'(bus.STALL_CYCLES), 32'd15);

    // Reset clears counters and watchdog
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle_outputs("rst2");
    check_eq("rst2_cycles", 32'(bus.STALL_CYCLES), 32'd0);
    check_eq("rst2_wdog",   32'(bus.WATCHDOG_TO),  32'd0);

    // Reset during PEND aborts the flush
    bus.EXCEPT_REQ = 1'b1;
    bus.EXCEPT_PC  = 32'h12345678;
    step();
    check_eq("abort_pend", 32'(bus.DBG_STATE), 32'd1);
    rst = 1'b1;
    bus.EXCEPT_REQ = 1'b0;
    step();
    rst = 1'b0;
    check_idle_outputs("abort_rst");
    step();
    check_idle_outputs("abort_after");
    step();
    check_eq("abort_flush_late", 32'(bus.FLUSH), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
